// File: rtl/gpi_edge_capture.sv
// Memory-mapped general-purpose input: two-flop synchronizer, tick-sampled debounce,
// W1C rising/falling edge flags and a level interrupt while any flag is pending.
module gpi_edge_capture #(
    parameter int unsigned WIDTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             wr_en,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] inPort,
    output logic             irq
);

    localparam logic [1:0] REG_IDR  = 2'd0;
    localparam logic [1:0] REG_RISE = 2'd1;
    localparam logic [1:0] REG_FALL = 2'd2;
    localparam logic [1:0] REG_CFG  = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] idr_q, idr_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      cfg_q, cfg_d;

    logic             tick;
    logic             wr_rise, wr_fall, wr_cfg;
    logic [WIDTH-1:0] agree, set_r, set_f;
    logic             unused_bits;

    assign unused_bits = ^{addr[1:0], wdata};

    assign wr_rise = ce && wr_en && (addr[3:2] == REG_RISE);
    assign wr_fall = ce && wr_en && (addr[3:2] == REG_FALL);
    assign wr_cfg  = ce && wr_en && (addr[3:2] == REG_CFG);

    assign tick = (cnt_q == cfg_q);

    always_comb begin
        samp_d = samp_q;
        idr_d  = idr_q;
        agree  = ~(samp_q ^ sync2_q);
        if (tick) begin
            samp_d = sync2_q;
            idr_d  = (idr_q & ~agree) | (sync2_q & agree);
        end
        set_r = idr_d & ~idr_q;
        set_f = ~idr_d & idr_q;

        // Clear first, then OR in new edges so a coincident edge survives the W1C.
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr_rise) rise_d = rise_d & ~wdata[WIDTH-1:0];
        if (wr_fall) fall_d = fall_d & ~wdata[WIDTH-1:0];
        rise_d = rise_d | set_r;
        fall_d = fall_d | set_f;

        cfg_d = cfg_q;
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (wr_cfg) begin
            cfg_d = wdata[15:0];
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            idr_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
            cfg_q   <= DIV_RESET;
        end else begin
            sync1_q <= inPort;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            idr_q   <= idr_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (ce) begin
            case (addr[3:2])
                REG_IDR:  rdata[WIDTH-1:0] = idr_q;
                REG_RISE: rdata[WIDTH-1:0] = rise_q;
                REG_FALL: rdata[WIDTH-1:0] = fall_q;
                REG_CFG:  rdata[15:0]      = cfg_q;
                default:  rdata = '0;
            endcase
        end
    end

    assign irq = (|rise_q) | (|fall_q);

endmodule

// File: tb/tb_gpi_edge_capture.sv
// Bench for gpi_edge_capture: directed scenarios plus a randomized run checked
// against a pin-history / tick-arithmetic reference model.
module tb_gpi_edge_capture;

    localparam int          WIDTH     = 4;
    localparam logic [15:0] DIV_RESET = 16'd0;

    logic             clk, reset, ce, wr_en, irq;
    logic [3:0]       addr;
    logic [31:0]      wdata, rdata;
    logic [WIDTH-1:0] inPort;

    int errors = 0;
    int checks = 0;

    gpi_edge_capture #(.WIDTH(WIDTH), .DIV_RESET(DIV_RESET)) dut (
        .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .inPort(inPort), .irq(irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: keeps the full pin history and derives ticks from the
    // edge count since the last counter restart.
    logic [WIDTH-1:0] m_hist[$];
    int               m_rst_e = -100;
    int               m_anchor = 0;
    logic [15:0]      m_cfg = DIV_RESET;
    logic [WIDTH-1:0] m_idr = '0, m_last = '0, m_rise = '0, m_fall = '0;
    int               m_e;
    logic [WIDTH-1:0] m_s, m_agree, m_nidr, m_setr, m_setf;

    always @(posedge clk) begin
        m_e = m_hist.size();
        m_hist.push_back(inPort);
        if (reset) begin
            m_rst_e  = m_e;
            m_anchor = m_e + 1;
            m_cfg    = DIV_RESET;
            m_idr    = '0;
            m_last   = '0;
            m_rise   = '0;
            m_fall   = '0;
        end else begin
            m_s    = (m_e - 2 > m_rst_e) ? m_hist[m_e-2] : '0;
            m_setr = '0;
            m_setf = '0;
            if (((m_e - m_anchor) % (int'(m_cfg) + 1)) == int'(m_cfg)) begin
                m_agree = ~(m_last ^ m_s);
                m_nidr  = (m_idr & ~m_agree) | (m_s & m_agree);
                m_setr  = m_nidr & ~m_idr;
                m_setf  = ~m_nidr & m_idr;
                m_idr   = m_nidr;
                m_last  = m_s;
            end
            if (ce && wr_en) begin
                case (addr[3:2])
                    2'd1: m_rise = m_rise & ~wdata[WIDTH-1:0];
                    2'd2: m_fall = m_fall & ~wdata[WIDTH-1:0];
                    2'd3: begin m_cfg = wdata[15:0]; m_anchor = m_e + 1; end
                    default: ;
                endcase
            end
            m_rise = m_rise | m_setr;
            m_fall = m_fall | m_setf;
        end
    end

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        ce = 1'b1; wr_en = 1'b0; addr = a;
        #1 v = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v, exp;
        reset = 1'b1; inPort = 4'b0101;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            rd(4'h0, v);
            exp = (i < 4) ? 32'h0 : 32'h5;
            checks++;
            if (v !== exp) begin
                errors++; $display("FAIL reset_idr edge%0d got=%h exp=%h", i, v, exp);
            end
        end
        rd(4'h4, v); checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL reset_rise got=%h exp=5", v); end
        rd(4'h8, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_fall got=%h exp=0", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got=%b exp=1", irq); end
    endtask

    task automatic test_w1c;
        logic [31:0] v;
        wr(4'h4, 32'h1);
        rd(4'h4, v); checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL w1c_rise got=%h exp=4", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq got=%b exp=1", irq); end
        inPort[2] = 1'b0;
        repeat (5) @(negedge clk);
        rd(4'h8, v); checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL w1c_fall2 got=%h exp=4", v); end
        inPort[2] = 1'b1;
        repeat (3) @(negedge clk);
        wr(4'h4, 32'h4);   // lands on the same edge that re-sets RISE[2]
        rd(4'h4, v); checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL set_wins got=%h exp=4", v); end
        wr(4'h4, 32'h4);
        rd(4'h4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", v); end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h8, 32'hFFFF_FFFF);
        wr(4'hC, 32'h3);
        inPort[1] = 1'b1;
        repeat (2) @(negedge clk);
        inPort[1] = 1'b0;
        repeat (12) @(negedge clk);
        rd(4'h0, v); checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL glitch_idr got=%h exp=5", v); end
        rd(4'h4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL glitch_rise got=%h exp=0", v); end
    endtask

    task automatic test_stable;
        logic [31:0] v;
        inPort[1] = 1'b1;
        repeat (10) @(negedge clk);
        rd(4'h0, v); checks++;
        if (v[1] !== 1'b1) begin errors++; $display("FAIL stable_idr got=%h exp=7", v); end
        rd(4'h4, v); checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL stable_rise got=%h exp=2", v); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fall_isolation;
        logic [31:0] v;
        inPort[3] = 1'b1;
        repeat (12) @(negedge clk);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h8, 32'hFFFF_FFFF);
        inPort[3] = 1'b0;
        repeat (12) @(negedge clk);
        rd(4'h8, v); checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL fall3 got=%h exp=8", v); end
        ce = 1'b0; wr_en = 1'b0; addr = 4'h8;
        #1 checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL ce0_rdata got=%h exp=0", rdata); end
        wr_en = 1'b1; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        wr_en = 1'b0;
        rd(4'h8, v); checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL ce0_write got=%h exp=8", v); end
    endtask

    task automatic test_cfg_reset;
        logic [31:0] v;
        wr(4'hC, 32'hABCD_1234);
        rd(4'hC, v); checks++;
        if (v !== 32'h0000_1234) begin errors++; $display("FAIL cfg_rb got=%h exp=1234", v); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(4'hC, v); checks++;
        if (v !== 32'(DIV_RESET)) begin errors++; $display("FAIL rst_cfg got=%h exp=%h", v, DIV_RESET); end
        rd(4'h4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rst_rise got=%h exp=0", v); end
        rd(4'h8, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rst_fall got=%h exp=0", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
    endtask

    task automatic test_random;
        logic [31:0] v;
        int r;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rd(4'h0, v); checks++;
            if (v !== 32'(m_idr)) begin errors++; $display("FAIL rnd_idr c%0d got=%h exp=%h", i, v, m_idr); end
            rd(4'h4, v); checks++;
            if (v !== 32'(m_rise)) begin errors++; $display("FAIL rnd_rise c%0d got=%h exp=%h", i, v, m_rise); end
            rd(4'h8, v); checks++;
            if (v !== 32'(m_fall)) begin errors++; $display("FAIL rnd_fall c%0d got=%h exp=%h", i, v, m_fall); end
            rd(4'hC, v); checks++;
            if (v !== 32'(m_cfg)) begin errors++; $display("FAIL rnd_cfg c%0d got=%h exp=%h", i, v, m_cfg); end
            checks++;
            if (irq !== ((|m_rise) | (|m_fall))) begin
                errors++; $display("FAIL rnd_irq c%0d got=%b", i, irq);
            end
            if ($urandom_range(0, 9) == 0) begin
                ce = 1'b0; addr = 4'($urandom_range(0, 15));
                #1 checks++;
                if (rdata !== 32'h0) begin errors++; $display("FAIL rnd_ce0 c%0d got=%h exp=0", i, rdata); end
            end
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 4) == 0) inPort = WIDTH'($urandom);
            r = $urandom_range(0, 11);
            wdata = $urandom;
            ce = 1'b1; wr_en = 1'b0; addr = 4'($urandom_range(0, 15));
            case (r)
                0: begin wr_en = 1'b1; addr = 4'hC; wdata[15:0] = 16'($urandom_range(0, 3)); end
                1, 2: begin wr_en = 1'b1; addr = 4'h4; end
                3, 4: begin wr_en = 1'b1; addr = 4'h8; end
                5: begin wr_en = 1'b1; ce = 1'b0; end
                6: begin wr_en = 1'b1; addr = 4'h0; end
                default: ;
            endcase
        end
        @(negedge clk);
        wr_en = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; inPort = '0;
        test_reset();
        test_w1c();
        test_glitch();
        test_stable();
        test_fall_isolation();
        test_cfg_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
